clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
- Mode/sequencing controller for the 6-digit digital clock (HH:MM:SS, BCD).
- Takes debounced key pulses and the running time from the counter. Runs the set-time and set-alarm edit sequences, commits edits to the counter, and raises the beep request on alarm match.
- Drives the display with the value to show plus a per-digit blink mask.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); minimum 2.
- RING_SECS, 60, sec_tick count after which an unacknowledged alarm stops by itself; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_pulse  in  4  debounced one-cycle pulses: [0]=MODE, [1]=NEXT, [2]=INC, [3]=OK
- sec_tick  in  1  one-cycle pulse per second from the counter
- time_bcd  in  24  current time {H1,H0,M1,M0,S1,S0}, 4-bit BCD each
- run_en  out  1  counter may advance
- set_en  out  1  one-cycle load strobe to the counter
- set_data  out  24  BCD time to load; valid only when set_en=1
- disp_data  out  24  BCD value for the display
- blink_mask  out  6  1 = blank that digit; bit5=H1 … bit0=S0
- beep_req  out  1  alarm sounding
- alarm_on  out  1  alarm armed
- mode  out  3  current state encoding, for debug/LEDs

Behaviour:
- Clock and reset: single clk domain; rst_n asynchronous active-low.
- Reset values: state RUN, run_en=1, set_en=0, set_data=0, beep_req=0, alarm_on=0, alarm register=07:00, edit shadows=0, blink phase=0, ring counter=0.
- States and encodings: RUN=0, SET_HH=1, SET_MM=2, SET_SS=3, ALM_HH=4, ALM_MM=5, RING=6.
- Simultaneous key pulses: only the highest-priority key acts, order MODE > OK > NEXT > INC.
- MODE key:
  - RUN → SET_HH; the time shadow loads time_bcd in the same cycle.
  - Any SET_* → ALM_HH; the time edit is discarded and the alarm shadow loads the alarm register.
  - Any ALM_* → RUN; the alarm edit is discarded.
  - RING → RUN; the ring is stopped.
- NEXT key:
  - SET fields cycle SET_HH → SET_MM → SET_SS → SET_HH.
  - Alarm fields cycle ALM_HH ↔ ALM_MM.
  - In RUN, NEXT toggles alarm_on.
  - In RING, NEXT stops the ring → RUN.
- INC key:
  - Increments the selected field of the active shadow, in BCD.
  - Hours wrap 23 → 00; minutes and seconds wrap 59 → 00.
  - Ones digit 9 → 0 with a carry into the tens digit; no carry into the neighbouring field.
  - In RING, INC stops the ring → RUN.
  - In RUN, INC is ignored.
- OK key:
  - SET_*: set_en=1 for exactly one cycle with set_data=time shadow, then → RUN.
  - ALM_*: alarm register ← shadow, alarm_on=1, then → RUN.
  - RING: stops the ring → RUN.
  - RUN: ignored.
- run_en: 0 in all SET_* states (counter frozen); 1 in every other state, including RING. run_en changes in the same cycle as the state register.
- Alarm match:
  - Triggers only in state RUN, with alarm_on=1.
  - Condition: sec_tick=1 AND time_bcd[23:8]=alarm AND time_bcd[7:0]=00 → RING on the next edge; the ring counter clears.
  - A match while in a SET_* or ALM_* state is lost; no deferred ring.
- RING:
  - beep_req=1 (registered, asserted in the RING state only).
  - Each sec_tick increments the ring counter; at RING_SECS the controller returns to RUN.
  - alarm_on stays 1 after the ring ends.
- disp_data:
  - RUN/RING: time_bcd.
  - SET_*: time shadow.
  - ALM_*: {alarm shadow, 8'h00}.
- Blink:
  - A free-running divider toggles the blink phase every BLINK_DIV cycles.
  - Divider and phase reset to 0 on every state change, so the edited field shows immediately.
  - In SET_*/ALM_*, when phase=1, the two digits of the selected field are 1 in blink_mask; otherwise blink_mask=0.
  - RUN/RING: blink_mask=0.
- Reset mid-edit: the shadow is discarded, set_en is never emitted and the state returns to RUN.
- Illegal state encoding (7): the FSM recovers to RUN on the next clock.

Test Plan:
- Commit time edit:
  - Stimulus: reset; time_bcd=12:34:56; MODE, INC×3, NEXT, INC, OK.
  - Response: run_en=0 while editing; set_en one cycle with set_data=15:35:56; then run_en=1, mode=0.
- BCD wrap:
  - Stimulus: in SET_HH with shadow 23; INC. In SET_MM with shadow 59; INC.
  - Response: hours=00; minutes=00; the other fields are unchanged.
- Alarm set and ring:
  - Stimulus: set alarm 07:01 via MODE, MODE, NEXT, INC, OK (alarm_on=1); drive time_bcd=07:01:00 with sec_tick.
  - Response: mode=6 and beep_req=1 the next cycle; after 60 sec_ticks beep_req=0 and mode=0.
- Ring acknowledge:
  - Stimulus: in RING, a NEXT pulse.
  - Response: beep_req=0 the next cycle, mode=0, alarm_on still 1.
- Priority and discard:
  - Stimulus: in SET_MM, MODE and OK pulse in the same cycle.
  - Response: no set_en; state ALM_HH; disp_data={07,00,00}.
- Blink and reset:
  - Stimulus: BLINK_DIV=4; enter SET_SS.
  - Response: blink_mask=0 for 4 cycles, then 6'b000011 for 4 cycles, repeating.
  - Stimulus: assert rst_n=0 mid-edit.
  - Response: outputs return to reset values immediately; no set_en.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode/sequencing controller for a 6-digit BCD clock: time/alarm edit
// sequences, counter load strobe, alarm ring and display blink control.
module clock_mode_ctrl #(
  parameter int BLINK_DIV = 25000000,
  parameter int RING_SECS = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_pulse,
  input  logic        sec_tick,
  input  logic [23:0] time_bcd,
  output logic        run_en,
  output logic        set_en,
  output logic [23:0] set_data,
  output logic [23:0] disp_data,
  output logic [5:0]  blink_mask,
  output logic        beep_req,
  output logic        alarm_on,
  output logic [2:0]  mode
);

  localparam int DIV_W = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_HH = 3'd1,
    ST_SET_MM = 3'd2,
    ST_SET_SS = 3'd3,
    ST_ALM_HH = 3'd4,
    ST_ALM_MM = 3'd5,
    ST_RING   = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [23:0]        r_tshadow,  w_tshadow_nxt;
  logic [15:0]        r_ashadow,  w_ashadow_nxt;
  logic [15:0]        r_alarm,    w_alarm_nxt;
  logic               r_alarm_on, w_alarm_on_nxt;
  logic               r_set_en,   w_set_en_nxt;
  logic [23:0]        r_set_data, w_set_data_nxt;
  logic [7:0]         r_ring_cnt, w_ring_nxt;
  logic               r_run_en;
  logic               r_beep;
  logic [DIV_W-1:0]   r_div;
  logic               r_phase;

  logic w_key_mode, w_key_ok, w_key_next, w_key_inc, w_key_any;
  logic w_alarm_hit;
  logic w_next_is_set;

  // BCD increment of a two-digit field, wrapping at max_val back to 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val >= max_val) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  assign w_key_mode = key_pulse[0];
  assign w_key_ok   = key_pulse[3] & ~key_pulse[0];
  assign w_key_next = key_pulse[1] & ~key_pulse[3] & ~key_pulse[0];
  assign w_key_inc  = key_pulse[2] & ~key_pulse[1] & ~key_pulse[3] & ~key_pulse[0];
  assign w_key_any  = |key_pulse;

  assign w_alarm_hit = r_alarm_on & sec_tick & (time_bcd[23:8] == r_alarm) & (time_bcd[7:0] == 8'h00);

  // Next-state and next-value logic for the FSM and its datapath registers
  always_comb begin
    w_state_nxt    = r_state;
    w_tshadow_nxt  = r_tshadow;
    w_ashadow_nxt  = r_ashadow;
    w_alarm_nxt    = r_alarm;
    w_alarm_on_nxt = r_alarm_on;
    w_set_en_nxt   = 1'b0;
    w_set_data_nxt = r_set_data;
    w_ring_nxt     = r_ring_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_key_mode) begin
          w_state_nxt   = ST_SET_HH;
          w_tshadow_nxt = time_bcd;
        end else if (w_key_next) begin
          w_alarm_on_nxt = ~r_alarm_on;
        end else if (w_alarm_hit) begin
          w_state_nxt = ST_RING;
          w_ring_nxt  = 8'd0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SET_HH, ST_SET_MM, ST_SET_SS: begin
        if (w_key_mode) begin
          w_state_nxt   = ST_ALM_HH;
          w_ashadow_nxt = r_alarm;
        end else if (w_key_ok) begin
          w_set_en_nxt   = 1'b1;
          w_set_data_nxt = r_tshadow;
          w_state_nxt    = ST_RUN;
        end else if (w_key_next) begin
          if (r_state == ST_SET_HH) begin
            w_state_nxt = ST_SET_MM;
          end else if (r_state == ST_SET_MM) begin
            w_state_nxt = ST_SET_SS;
          end else begin
            w_state_nxt = ST_SET_HH;
          end
        end else if (w_key_inc) begin
          if (r_state == ST_SET_HH) begin
            w_tshadow_nxt[23:16] = bcd_inc(r_tshadow[23:16], 8'h23);
          end else if (r_state == ST_SET_MM) begin
            w_tshadow_nxt[15:8] = bcd_inc(r_tshadow[15:8], 8'h59);
          end else begin
            w_tshadow_nxt[7:0] = bcd_inc(r_tshadow[7:0], 8'h59);
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ALM_HH, ST_ALM_MM: begin
        if (w_key_mode) begin
          w_state_nxt = ST_RUN;
        end else if (w_key_ok) begin
          w_alarm_nxt    = r_ashadow;
          w_alarm_on_nxt = 1'b1;
          w_state_nxt    = ST_RUN;
        end else if (w_key_next) begin
          w_state_nxt = (r_state == ST_ALM_HH) ? ST_ALM_MM : ST_ALM_HH;
        end else if (w_key_inc) begin
          if (r_state == ST_ALM_HH) begin
            w_ashadow_nxt[15:8] = bcd_inc(r_ashadow[15:8], 8'h23);
          end else begin
            w_ashadow_nxt[7:0] = bcd_inc(r_ashadow[7:0], 8'h59);
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RING: begin
        if (w_key_any) begin
          w_state_nxt = ST_RUN;
        end else if (sec_tick) begin
          w_ring_nxt = r_ring_cnt + 8'd1;
          if (r_ring_cnt >= RING_LAST) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_RING;
          end
        end else begin
          w_state_nxt = ST_RING;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_next_is_set = (w_state_nxt == ST_SET_HH) || (w_state_nxt == ST_SET_MM) ||
                         (w_state_nxt == ST_SET_SS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs; run_en/beep track the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tshadow  <= 24'h000000;
      r_ashadow  <= 16'h0000;
      r_alarm    <= 16'h0700;
      r_alarm_on <= 1'b0;
      r_set_en   <= 1'b0;
      r_set_data <= 24'h000000;
      r_ring_cnt <= 8'd0;
      r_run_en   <= 1'b1;
      r_beep     <= 1'b0;
    end else begin
      r_tshadow  <= w_tshadow_nxt;
      r_ashadow  <= w_ashadow_nxt;
      r_alarm    <= w_alarm_nxt;
      r_alarm_on <= w_alarm_on_nxt;
      r_set_en   <= w_set_en_nxt;
      r_set_data <= w_set_data_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_run_en   <= ~w_next_is_set;
      r_beep     <= (w_state_nxt == ST_RING);
    end
  end

  // Blink divider restarts on every state change so the new field shows at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (w_state_nxt != r_state) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  // Display value and blink mask decoded from registered state
  always_comb begin
    disp_data  = time_bcd;
    blink_mask = 6'b000000;
    case (r_state)
      ST_SET_HH: begin
        disp_data  = r_tshadow;
        blink_mask = r_phase ? 6'b110000 : 6'b000000;
      end
      ST_SET_MM: begin
        disp_data  = r_tshadow;
        blink_mask = r_phase ? 6'b001100 : 6'b000000;
      end
      ST_SET_SS: begin
        disp_data  = r_tshadow;
        blink_mask = r_phase ? 6'b000011 : 6'b000000;
      end
      ST_ALM_HH: begin
        disp_data  = {r_ashadow, 8'h00};
        blink_mask = r_phase ? 6'b110000 : 6'b000000;
      end
      ST_ALM_MM: begin
        disp_data  = {r_ashadow, 8'h00};
        blink_mask = r_phase ? 6'b001100 : 6'b000000;
      end
      default: begin
        disp_data  = time_bcd;
        blink_mask = 6'b000000;
      end
    endcase
  end

  assign run_en   = r_run_en;
  assign set_en   = r_set_en;
  assign set_data = r_set_data;
  assign beep_req = r_beep;
  assign alarm_on = r_alarm_on;
  assign mode     = r_state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: scoreboard of expected load
// strobes plus per-scenario inline checks.
module tb_clock_mode_ctrl;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_NEXT = 4'b0010;
  localparam logic [3:0] K_INC  = 4'b0100;
  localparam logic [3:0] K_OK   = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_pulse = 4'b0000;
  logic        sec_tick = 1'b0;
  logic [23:0] time_bcd = 24'h000000;
  logic        run_en, set_en, beep_req, alarm_on;
  logic [23:0] set_data, disp_data;
  logic [5:0]  blink_mask;
  logic [2:0]  mode;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] sb_q[$];

  clock_mode_ctrl #(.BLINK_DIV(4), .RING_SECS(60)) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .sec_tick(sec_tick),
    .time_bcd(time_bcd), .run_en(run_en), .set_en(set_en), .set_data(set_data),
    .disp_data(disp_data), .blink_mask(blink_mask), .beep_req(beep_req),
    .alarm_on(alarm_on), .mode(mode)
  );

  always #5 clk = ~clk;

  // Every load strobe must match the next expected value in the scoreboard
  always @(negedge clk) begin
    if (rst_n && set_en === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_set_en: set_data=%h, required no strobe", set_data);
      end else begin
        logic [23:0] exp_v;
        exp_v = sb_q.pop_front();
        if (set_data !== exp_v) begin
          n_fail++;
          $display("FAIL sb_set_data: got %h, required %h", set_data, exp_v);
        end
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_pulse = k;
    @(negedge clk);
    key_pulse = 4'b0000;
  endtask

  task automatic tick();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    time_bcd = 24'h112233;
    repeat (2) @(negedge clk);
    chk("rst_mode", {21'd0, mode}, 24'd0);
    chk("rst_run_en", {23'd0, run_en}, 24'd1);
    chk("rst_set_en", {23'd0, set_en}, 24'd0);
    chk("rst_set_data", set_data, 24'h000000);
    chk("rst_beep", {23'd0, beep_req}, 24'd0);
    chk("rst_alarm_on", {23'd0, alarm_on}, 24'd0);
    chk("rst_blink", {18'd0, blink_mask}, 24'd0);
    chk("rst_disp", disp_data, 24'h112233);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_commit();
    time_bcd = 24'h123456;
    press(K_INC);
    chk("run_inc_ignored", {21'd0, mode}, 24'd0);
    press(K_MODE);
    chk("commit_mode_sethh", {21'd0, mode}, 24'd1);
    chk("commit_run_en0", {23'd0, run_en}, 24'd0);
    chk("commit_shadow_load", disp_data, 24'h123456);
    repeat (3) press(K_INC);
    press(K_NEXT);
    chk("commit_mode_setmm", {21'd0, mode}, 24'd2);
    press(K_INC);
    chk("commit_disp", disp_data, 24'h153556);
    sb_q.push_back(24'h153556);
    press(K_OK);
    chk("commit_set_en", {23'd0, set_en}, 24'd1);
    chk("commit_mode_run", {21'd0, mode}, 24'd0);
    chk("commit_run_en1", {23'd0, run_en}, 24'd1);
    @(negedge clk);
    chk("commit_set_en_1cyc", {23'd0, set_en}, 24'd0);
  endtask

  task automatic test_bcd_wrap();
    time_bcd = 24'h095910;
    press(K_MODE);
    press(K_INC);
    chk("wrap_carry_09_10", disp_data, 24'h105910);
    repeat (13) press(K_INC);
    chk("wrap_hh_23", disp_data, 24'h235910);
    press(K_INC);
    chk("wrap_hh_00", disp_data, 24'h005910);
    press(K_NEXT);
    press(K_INC);
    chk("wrap_mm_00", disp_data, 24'h000010);
    press(K_MODE);
    chk("wrap_discard_alm", {21'd0, mode}, 24'd4);
    chk("wrap_alm_disp", disp_data, 24'h070000);
    press(K_MODE);
    chk("wrap_back_run", {21'd0, mode}, 24'd0);
  endtask

  task automatic test_priority();
    time_bcd = 24'h120000;
    press(K_MODE);
    press(K_NEXT | K_INC);
    chk("prio_next_over_inc", {21'd0, mode}, 24'd2);
    chk("prio_no_inc", disp_data, 24'h120000);
    press(K_MODE | K_OK);
    chk("prio_mode_over_ok", {21'd0, mode}, 24'd4);
    chk("prio_no_set_en", {23'd0, set_en}, 24'd0);
    chk("prio_alm_disp", disp_data, 24'h070000);
    press(K_OK | K_NEXT | K_INC);
    chk("prio_ok_commit_alm", {21'd0, mode}, 24'd0);
    chk("prio_alarm_on", {23'd0, alarm_on}, 24'd1);
    press(K_NEXT);
    chk("prio_toggle_off", {23'd0, alarm_on}, 24'd0);
  endtask

  task automatic test_blink_reset();
    logic [5:0] exp_m;
    press(K_MODE);
    chk("blink_hh_entry", {18'd0, blink_mask}, 24'd0);
    repeat (4) @(negedge clk);
    chk("blink_hh_on", {18'd0, blink_mask}, {18'd0, 6'b110000});
    press(K_NEXT);
    chk("blink_restart", {18'd0, blink_mask}, 24'd0);
    press(K_NEXT);
    chk("blink_mode_ss", {21'd0, mode}, 24'd3);
    for (int i = 0; i < 12; i++) begin
      exp_m = (((i / 4) % 2) == 1) ? 6'b000011 : 6'b000000;
      chk($sformatf("blink_ss_%0d", i), {18'd0, blink_mask}, {18'd0, exp_m});
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mode", {21'd0, mode}, 24'd0);
    chk("midrst_run_en", {23'd0, run_en}, 24'd1);
    chk("midrst_set_data", set_data, 24'h000000);
    chk("midrst_blink", {18'd0, blink_mask}, 24'd0);
    chk("midrst_disp", disp_data, time_bcd);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_set_en", {23'd0, set_en}, 24'd0);
  endtask

  task automatic test_alarm_ring();
    time_bcd = 24'h065959;
    press(K_MODE);
    press(K_MODE);
    press(K_NEXT);
    press(K_INC);
    chk("alm_disp_0701", disp_data, 24'h070100);
    press(K_OK);
    chk("alm_commit_run", {21'd0, mode}, 24'd0);
    chk("alm_on", {23'd0, alarm_on}, 24'd1);
    time_bcd = 24'h070100;
    tick();
    chk("ring_mode", {21'd0, mode}, 24'd6);
    chk("ring_beep", {23'd0, beep_req}, 24'd1);
    chk("ring_run_en", {23'd0, run_en}, 24'd1);
    repeat (59) tick();
    chk("ring_still_59", {21'd0, mode}, 24'd6);
    tick();
    chk("ring_timeout_mode", {21'd0, mode}, 24'd0);
    chk("ring_timeout_beep", {23'd0, beep_req}, 24'd0);
    chk("ring_timeout_alm_on", {23'd0, alarm_on}, 24'd1);
    time_bcd = 24'h070101;
  endtask

  task automatic test_ring_ack();
    time_bcd = 24'h070100;
    tick();
    chk("ack_ring", {21'd0, mode}, 24'd6);
    press(K_NEXT);
    chk("ack_mode", {21'd0, mode}, 24'd0);
    chk("ack_beep", {23'd0, beep_req}, 24'd0);
    chk("ack_alm_on", {23'd0, alarm_on}, 24'd1);
    time_bcd = 24'h070130;
    tick();
    chk("nomatch_secs", {21'd0, mode}, 24'd0);
    time_bcd = 24'h070100;
    press(K_NEXT);
    tick();
    chk("disarmed_no_ring", {21'd0, mode}, 24'd0);
    press(K_NEXT);
    press(K_MODE);
    tick();
    chk("lost_match_set", {21'd0, mode}, 24'd1);
    press(K_MODE);
    press(K_MODE);
    chk("lost_match_run", {21'd0, mode}, 24'd0);
    chk("lost_match_beep", {23'd0, beep_req}, 24'd0);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_bcd_wrap();
    test_priority();
    test_blink_reset();
    test_alarm_ring();
    test_ring_ack();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_pending: %0d strobes outstanding, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
